// File: rtl/mem_ctl_fsm.sv
// mem_ctl_fsm: registered memory-access controller between a 4-phase
// requester port and a 4-phase memory strobe/done port.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   din_valid, wen, din_addr,
//   din_data, din_ack             requester request channel (4-phase)
//   dout_valid, dout_ack,
//   dout_data                     read-data return channel (4-phase)
//   mem_write, mem_read, mem_addr,
//   mem_wdata, mem_rdata, mem_done memory strobe/done channel (4-phase)
//   err, err_clr                  sticky timeout flag and its clear
//   wr_cnt, rd_cnt                saturating completed-transaction counters
//
// Every output is a register and is updated on the same edge as the
// state transition that defines it.
module mem_ctl_fsm #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic              wen,
  input  logic [ADDR_W-1:0] din_addr,
  input  logic [DATA_W-1:0] din_data,
  output logic              din_ack,
  output logic              dout_valid,
  input  logic              dout_ack,
  output logic [DATA_W-1:0] dout_data,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, WR_REQ, WR_REL, WR_ACK, RD_REQ, RD_ACK, RD_OUT, RD_OREL, RD_REL, ERR
  } state_t;

  state_t              state_q;
  logic [TW-1:0]       tmo_q;
  logic                din_ack_q, dout_valid_q, mem_write_q, mem_read_q, err_q;
  logic [DATA_W-1:0]   dout_data_q, mem_wdata_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [CNT_W-1:0]    wr_cnt_q, rd_cnt_q;

  // The four memory-waiting states and whether the awaited mem_done level
  // has arrived; the timeout only runs while waiting and unsatisfied.
  logic waiting, wait_met, tmo_exp;
  always_comb begin
    waiting  = 1'b0;
    wait_met = 1'b0;
    case (state_q)
      WR_REQ, RD_REQ: begin waiting = 1'b1; wait_met = mem_done;  end
      WR_REL, RD_REL: begin waiting = 1'b1; wait_met = !mem_done; end
      default: ;
    endcase
    tmo_exp = (TIMEOUT != 0) && (tmo_q == TMO_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      din_ack_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      err_q        <= 1'b0;
      dout_data_q  <= '0;
      mem_wdata_q  <= '0;
      mem_addr_q   <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
    end else begin
      // Counter restarts on any state change; it only advances while stuck.
      if (waiting && !wait_met && TIMEOUT != 0) tmo_q <= tmo_q + 1'b1;
      else                                      tmo_q <= '0;

      if (err_clr) err_q <= 1'b0;

      if (waiting && !wait_met && tmo_exp) begin
        // Set wins over a simultaneous clear.
        state_q      <= ERR;
        tmo_q        <= '0;
        mem_write_q  <= 1'b0;
        mem_read_q   <= 1'b0;
        dout_valid_q <= 1'b0;
        din_ack_q    <= 1'b1;
        err_q        <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (din_valid) begin
            mem_addr_q  <= din_addr;
            mem_wdata_q <= din_data;
            if (wen) begin state_q <= WR_REQ; mem_write_q <= 1'b1; end
            else     begin state_q <= RD_REQ; mem_read_q  <= 1'b1; end
          end
          WR_REQ: if (mem_done)   begin state_q <= WR_REL; mem_write_q <= 1'b0; end
          WR_REL: if (!mem_done)  begin state_q <= WR_ACK; din_ack_q   <= 1'b1; end
          WR_ACK: if (!din_valid) begin
            state_q   <= IDLE;
            din_ack_q <= 1'b0;
            if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 1'b1;
          end
          RD_REQ: if (mem_done) begin
            state_q     <= RD_ACK;
            dout_data_q <= mem_rdata;
            din_ack_q   <= 1'b1;
          end
          RD_ACK: if (!din_valid) begin
            state_q      <= RD_OUT;
            din_ack_q    <= 1'b0;
            dout_valid_q <= 1'b1;
          end
          RD_OUT:  if (dout_ack)  begin state_q <= RD_OREL; dout_valid_q <= 1'b0; end
          // mem_read is held through the output handshake and released last.
          RD_OREL: if (!dout_ack) begin state_q <= RD_REL;  mem_read_q   <= 1'b0; end
          RD_REL: if (!mem_done) begin
            state_q <= IDLE;
            if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 1'b1;
          end
          ERR: if (!din_valid) begin state_q <= IDLE; din_ack_q <= 1'b0; end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign din_ack    = din_ack_q;
  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;
  assign mem_write  = mem_write_q;
  assign mem_read   = mem_read_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign err        = err_q;
  assign wr_cnt     = wr_cnt_q;
  assign rd_cnt     = rd_cnt_q;

endmodule

// File: tb/tb_mem_ctl_fsm.sv
// Testbench for mem_ctl_fsm (TIMEOUT=4, CNT_W=2): table of directed vectors
// for the write/read/back-to-back flows, then hand-written sequences for
// timeout, reset mid-read and counter saturation.
module tb_mem_ctl_fsm;

  logic        clk = 1'b0;
  logic        rst, din_valid, wen, mem_done, dout_ack, err_clr;
  logic [7:0]  din_addr;
  logic [15:0] din_data, mem_rdata;
  logic        din_ack, dout_valid, mem_write, mem_read, err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, dout_data;
  logic [1:0]  wr_cnt, rd_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_ctl_fsm #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .wen(wen),
    .din_addr(din_addr), .din_data(din_data), .din_ack(din_ack),
    .dout_valid(dout_valid), .dout_ack(dout_ack), .dout_data(dout_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .err(err), .err_clr(err_clr), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  typedef struct packed {
    logic        ack, dvl, mw, mr;
    logic [7:0]  ma;
    logic [15:0] mwd, dd;
    logic        e;
    logic [1:0]  wc, rc;
  } exp_t;

  typedef struct packed {
    logic        r, dv, we;
    logic [7:0]  a;
    logic [15:0] d;
    logic        md;
    logic [15:0] rd;
    logic        dk, ec;
    exp_t        x;
  } vec_t;

  exp_t act;
  assign act = '{din_ack, dout_valid, mem_write, mem_read, mem_addr,
                 mem_wdata, dout_data, err, wr_cnt, rd_cnt};

  function automatic vec_t mk(
    input logic r, dv, we, input logic [7:0] a, input logic [15:0] d,
    input logic md, input logic [15:0] rd, input logic dk, ec,
    input logic ack, dvl, mw, mr, input logic [7:0] ma,
    input logic [15:0] mwd, dd, input logic e, input logic [1:0] wc, rc);
    vec_t v;
    v.r = r; v.dv = dv; v.we = we; v.a = a; v.d = d; v.md = md; v.rd = rd;
    v.dk = dk; v.ec = ec;
    v.x = '{ack, dvl, mw, mr, ma, mwd, dd, e, wc, rc};
    return v;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    din_valid = 1; wen = 1; din_addr = a; din_data = d; step();
    mem_done = 1; step();
    mem_done = 0; step();
    din_valid = 0; step();
  endtask

  vec_t tv[23];

  initial begin
    rst = 1; din_valid = 0; wen = 0; din_addr = '0; din_data = '0;
    mem_done = 0; mem_rdata = '0; dout_ack = 0; err_clr = 0;

    //            r dv we addr   data     md rdata    dk ec | ack dvl mw mr addr   wdata    dout     e wc rc
    tv[0]  = mk(1,0,0,8'h00,16'h0000,0,16'h0000,0,0, 0,0,0,0,8'h00,16'h0000,16'h0000,0,0,0);
    tv[1]  = mk(0,1,1,8'h3A,16'hBEEF,0,16'h0000,0,0, 0,0,1,0,8'h3A,16'hBEEF,16'h0000,0,0,0);
    tv[2]  = mk(0,1,1,8'h11,16'h0000,1,16'h0000,0,0, 0,0,0,0,8'h3A,16'hBEEF,16'h0000,0,0,0);
    tv[3]  = mk(0,1,0,8'h11,16'h0000,0,16'h0000,0,0, 1,0,0,0,8'h3A,16'hBEEF,16'h0000,0,0,0);
    tv[4]  = mk(0,0,0,8'h11,16'h0000,0,16'h0000,0,0, 0,0,0,0,8'h3A,16'hBEEF,16'h0000,0,1,0);
    tv[5]  = mk(0,0,0,8'h11,16'h0000,1,16'h0000,1,0, 0,0,0,0,8'h3A,16'hBEEF,16'h0000,0,1,0);
    tv[6]  = mk(0,1,0,8'h05,16'hAAAA,0,16'h0000,0,0, 0,0,0,1,8'h05,16'hAAAA,16'h0000,0,1,0);
    tv[7]  = mk(0,1,1,8'h05,16'hAAAA,1,16'h1234,0,0, 1,0,0,1,8'h05,16'hAAAA,16'h1234,0,1,0);
    tv[8]  = mk(0,0,1,8'h05,16'hAAAA,1,16'hFFFF,0,0, 0,1,0,1,8'h05,16'hAAAA,16'h1234,0,1,0);
    tv[9]  = mk(0,0,0,8'h05,16'hAAAA,1,16'hFFFF,1,0, 0,0,0,1,8'h05,16'hAAAA,16'h1234,0,1,0);
    tv[10] = mk(0,0,0,8'h05,16'hAAAA,1,16'hFFFF,0,0, 0,0,0,0,8'h05,16'hAAAA,16'h1234,0,1,0);
    tv[11] = mk(0,0,0,8'h05,16'hAAAA,0,16'hFFFF,0,0, 0,0,0,0,8'h05,16'hAAAA,16'h1234,0,1,1);
    tv[12] = mk(1,0,0,8'h00,16'h0000,0,16'h0000,0,0, 0,0,0,0,8'h00,16'h0000,16'h0000,0,0,0);
    tv[13] = mk(0,1,1,8'h7F,16'h0102,0,16'h0000,0,0, 0,0,1,0,8'h7F,16'h0102,16'h0000,0,0,0);
    tv[14] = mk(0,1,1,8'h7F,16'h0102,1,16'h0000,0,0, 0,0,0,0,8'h7F,16'h0102,16'h0000,0,0,0);
    tv[15] = mk(0,1,1,8'h7F,16'h0102,0,16'h0000,0,0, 1,0,0,0,8'h7F,16'h0102,16'h0000,0,0,0);
    tv[16] = mk(0,0,1,8'h7F,16'h0102,0,16'h0000,0,0, 0,0,0,0,8'h7F,16'h0102,16'h0000,0,1,0);
    tv[17] = mk(0,1,0,8'h22,16'h0003,0,16'h0000,0,0, 0,0,0,1,8'h22,16'h0003,16'h0000,0,1,0);
    tv[18] = mk(0,1,0,8'h22,16'h0003,1,16'h5A5A,0,0, 1,0,0,1,8'h22,16'h0003,16'h5A5A,0,1,0);
    tv[19] = mk(0,0,0,8'h22,16'h0003,1,16'h5A5A,0,0, 0,1,0,1,8'h22,16'h0003,16'h5A5A,0,1,0);
    tv[20] = mk(0,0,0,8'h22,16'h0003,1,16'h5A5A,1,0, 0,0,0,1,8'h22,16'h0003,16'h5A5A,0,1,0);
    tv[21] = mk(0,0,0,8'h22,16'h0003,1,16'h5A5A,0,0, 0,0,0,0,8'h22,16'h0003,16'h5A5A,0,1,0);
    tv[22] = mk(0,0,0,8'h22,16'h0003,0,16'h5A5A,0,0, 0,0,0,0,8'h22,16'h0003,16'h5A5A,0,1,1);

    for (int i = 0; i < 23; i++) begin
      rst = tv[i].r; din_valid = tv[i].dv; wen = tv[i].we; din_addr = tv[i].a;
      din_data = tv[i].d; mem_done = tv[i].md; mem_rdata = tv[i].rd;
      dout_ack = tv[i].dk; err_clr = tv[i].ec;
      step();
      chk($sformatf("vec%0d", i), 64'(act), 64'(tv[i].x));
    end

    // Timeout on a write: mem_done never rises.
    din_valid = 1; wen = 1; din_addr = 8'h40; din_data = 16'h9999; mem_done = 0;
    step();
    chk("tmo_wr_rise", 64'(mem_write), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("tmo_wait%0d", i), 64'({mem_write, err, din_ack}), 64'(3'b100));
    end
    err_clr = 1;  // coincides with err being set and must lose
    step();
    chk("tmo_err_entry", 64'({mem_write, mem_read, dout_valid, din_ack, err}), 64'(5'b00011));
    err_clr = 0;
    step();
    chk("tmo_err_hold", 64'({din_ack, err}), 64'(2'b11));
    din_valid = 0;
    step();
    chk("tmo_err_exit", 64'({din_ack, err, wr_cnt, rd_cnt}), 64'(6'b0_1_01_01));
    err_clr = 1;
    step();
    chk("tmo_err_clr", 64'(err), 64'd0);
    err_clr = 0;

    // Reset asserted in RD_OUT.
    din_valid = 1; wen = 0; din_addr = 8'h05; din_data = 16'h0000; step();
    mem_done = 1; mem_rdata = 16'hCAFE; step();
    din_valid = 0; step();
    chk("rst_pre_rdout", 64'({dout_valid, dout_data}), 64'({1'b1, 16'hCAFE}));
    rst = 1; step();
    chk("rst_mid_read", 64'(act), 64'd0);
    rst = 0; mem_done = 0;
    din_valid = 1; din_addr = 8'h06; step();
    chk("rd2_req", 64'({mem_read, mem_addr}), 64'({1'b1, 8'h06}));
    mem_done = 1; mem_rdata = 16'h0BAD; step();
    din_valid = 0; step();
    dout_ack = 1; step();
    dout_ack = 0; step();
    mem_done = 0; step();
    chk("rd2_done", 64'({mem_read, dout_valid, din_ack, dout_data, rd_cnt, wr_cnt}),
        64'({3'b000, 16'h0BAD, 2'd1, 2'd0}));

    // Saturation of a 2-bit write counter.
    for (int i = 1; i <= 5; i++) begin
      do_write(8'(i), 16'(i));
      chk($sformatf("wr_sat%0d", i), 64'(wr_cnt), 64'((i > 3) ? 3 : i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
